// File: rtl/edge_detector_multi.sv
// N-channel edge detector: per-channel synchroniser, debounce filter and mode-selected pulse,
// with sticky pending/missed flags and one aggregated interrupt.
module edge_detector_multi #(
  parameter int unsigned N             = 4,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   signal_in,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   irq_en,
  input  logic [N-1:0]   clear,
  output logic [N-1:0]   level_out,
  output logic [N-1:0]   edge_pulse,
  output logic [N-1:0]   edge_dir,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   missed,
  output logic           irq
);

  localparam int unsigned   CW      = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync [N];
  logic [CW-1:0]          r_cnt  [N];
  logic [N-1:0]           r_level, r_pulse, r_dir, r_pending, r_missed;

  logic [CW-1:0] w_cnt_d [N];
  logic [N-1:0]  w_s, w_level_d, w_fire, w_dir_d, w_pending_d, w_missed_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_s[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_level_d   = r_level;
    w_fire      = '0;
    w_dir_d     = r_dir;
    w_pending_d = r_pending;
    w_missed_d  = r_missed;
    for (int i = 0; i < N; i++) begin
      w_cnt_d[i] = '0;
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] == CntLast) begin
          w_level_d[i] = w_s[i];
          // mode[2i] enables rising, mode[2i+1] enables falling
          w_fire[i]    = w_s[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CW'(1);
        end
      end
      if (clear[i]) begin
        w_pending_d[i] = 1'b0;
        w_missed_d[i]  = 1'b0;
      end
      // A new event beats a coincident clear, but is then not counted as an overflow
      if (w_fire[i]) begin
        w_dir_d[i]     = w_s[i];
        w_pending_d[i] = 1'b1;
        if (r_pending[i] && !clear[i]) begin
          w_missed_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_sync[i] <= {SYNC_STAGES{RESET_LEVEL}};
        r_cnt[i]  <= '0;
      end
      r_level   <= {N{RESET_LEVEL}};
      r_pulse   <= '0;
      r_dir     <= '0;
      r_pending <= '0;
      r_missed  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], signal_in[i]};
        r_cnt[i]  <= w_cnt_d[i];
      end
      r_level   <= w_level_d;
      r_pulse   <= w_fire;
      r_dir     <= w_dir_d;
      r_pending <= w_pending_d;
      r_missed  <= w_missed_d;
    end
  end

  assign level_out  = r_level;
  assign edge_pulse = r_pulse;
  assign edge_dir   = r_dir;
  assign pending    = r_pending;
  assign missed     = r_missed;
  assign irq        = |(r_pending & irq_en);

endmodule

// File: tb/tb_edge_detector_multi.sv
// Scoreboard bench for edge_detector_multi: stimulus queues expected pulses, a negedge monitor
// pops and compares them; status flags are checked directly at quiet points.
module tb_edge_detector_multi;

  localparam int N   = 4;
  localparam int SS  = 3;
  localparam int FC  = 4;
  localparam int LAT = SS + FC;

  logic           clk, rst;
  logic [N-1:0]   signal_in, irq_en, clear;
  logic [2*N-1:0] mode;
  logic [N-1:0]   level_out, edge_pulse, edge_dir, pending, missed;
  logic           irq;

  edge_detector_multi #(
    .N(N), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .irq_en(irq_en),
    .clear(clear), .level_out(level_out), .edge_pulse(edge_pulse), .edge_dir(edge_dir),
    .pending(pending), .missed(missed), .irq(irq)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] pulse;
    logic [N-1:0] dir;
  } ev_t;

  ev_t          q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           exp_cnt[N];
  int           got_cnt[N];
  logic [N-1:0] prev_pulse = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected pulse LAT edges after the current cycle; merges same-cycle events
  task automatic push(input logic [N-1:0] pmask, input logic [N-1:0] dir);
    ev_t e;
    int  c;
    c = cyc + LAT;
    for (int i = 0; i < N; i++) if (pmask[i]) exp_cnt[i]++;
    if (q.size() > 0 && q[q.size()-1].cyc == c) begin
      e = q.pop_back();
      e.pulse |= pmask;
      e.dir   |= dir & pmask;
    end else begin
      e.cyc   = c;
      e.pulse = pmask;
      e.dir   = dir & pmask;
    end
    q.push_back(e);
  endtask

  task automatic set_in(input int ch, input logic v, input logic expect_pulse);
    signal_in[ch] = v;
    if (expect_pulse) push(N'(1) << ch, {N{v}});
  endtask

  task automatic do_clear(input logic [N-1:0] m);
    clear = m;
    step(1);
    clear = '0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_pulse got=none exp=%0h at cycle %0d", q[0].pulse, q[0].cyc);
      void'(q.pop_front());
    end
    if (edge_pulse != '0) begin
      for (int i = 0; i < N; i++) begin
        if (edge_pulse[i]) begin
          got_cnt[i]++;
          chk($sformatf("pulse_width_ch%0d", i), 32'(prev_pulse[i]), 32'd0);
        end
      end
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(edge_pulse), 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_vec", 32'(edge_pulse), 32'(e.pulse));
        chk("pulse_dir", 32'(edge_dir & e.pulse), 32'(e.dir));
      end
    end
    prev_pulse = edge_pulse;
  end

  initial begin
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin
      exp_cnt[i] = 0;
      got_cnt[i] = 0;
    end
    rst       = 1'b1;
    signal_in = '0;
    clear     = '0;
    irq_en    = 4'b1000;
    mode      = 8'b01_00_11_01;
    step(3);
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_outs", 32'({edge_pulse, edge_dir, pending, missed}), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    step(5);

    // ch0 rising only: pulse after LAT edges, falling tracked silently
    set_in(0, 1'b1, 1'b1);
    step(LAT + 2);
    chk("ch0_level_hi", 32'(level_out[0]), 32'd1);
    chk("ch0_pending", 32'(pending[0]), 32'd1);
    chk("ch0_irq_masked", 32'(irq), 32'd0);
    set_in(0, 1'b0, 1'b0);
    step(LAT - 1);
    chk("ch0_level_latency", 32'(level_out[0]), 32'd1);
    step(1);
    chk("ch0_level_lo", 32'(level_out[0]), 32'd0);
    do_clear(4'b0001);
    chk("ch0_cleared", 32'(pending[0]), 32'd0);

    // ch1 both edges: short glitch rejected, longer pulse accepted both ways
    set_in(1, 1'b1, 1'b0);
    step(FC - 1);
    set_in(1, 1'b0, 1'b0);
    step(12);
    chk("ch1_glitch_level", 32'(level_out[1]), 32'd0);
    chk("ch1_glitch_pending", 32'(pending[1]), 32'd0);
    set_in(1, 1'b1, 1'b1);
    step(6);
    set_in(1, 1'b0, 1'b1);
    step(LAT + 3);
    chk("ch1_dir_fall", 32'(edge_dir[1]), 32'd0);
    chk("ch1_missed", 32'({pending[1], missed[1]}), 32'b11);
    do_clear(4'b0010);

    // ch2 off: level follows, no events; then falling-only
    set_in(2, 1'b1, 1'b0);
    step(LAT + 2);
    chk("ch2_off_level_hi", 32'(level_out[2]), 32'd1);
    set_in(2, 1'b0, 1'b0);
    step(LAT + 2);
    chk("ch2_off_level_lo", 32'(level_out[2]), 32'd0);
    chk("ch2_off_pending", 32'(pending[2]), 32'd0);
    mode[5:4] = 2'b10;
    step(LAT + 2);
    set_in(2, 1'b1, 1'b0);
    step(LAT + 2);
    set_in(2, 1'b0, 1'b1);
    step(LAT + 2);
    chk("ch2_fall_pending", 32'(pending[2]), 32'd1);
    do_clear(4'b0100);

    // ch3 rising with irq: overflow, masking, clear, clear-vs-set
    set_in(3, 1'b1, 1'b1);
    step(LAT + 2);
    chk("ch3_irq_first", 32'({irq, pending[3], missed[3]}), 32'b110);
    set_in(3, 1'b0, 1'b0);
    step(LAT + 2);
    set_in(3, 1'b1, 1'b1);
    step(LAT + 2);
    chk("ch3_overflow", 32'({irq, pending[3], missed[3]}), 32'b111);
    irq_en[3] = 1'b0;
    #1;
    chk("ch3_irq_mask", 32'({irq, pending[3]}), 32'b01);
    irq_en[3] = 1'b1;
    #1;
    chk("ch3_irq_unmask", 32'(irq), 32'd1);
    do_clear(4'b1000);
    chk("ch3_clear", 32'({irq, pending[3], missed[3]}), 32'b000);
    set_in(3, 1'b0, 1'b0);
    step(LAT + 2);
    set_in(3, 1'b1, 1'b1);
    step(LAT + 2);
    set_in(3, 1'b0, 1'b0);
    step(LAT + 2);
    set_in(3, 1'b1, 1'b1);
    step(LAT - 1);
    clear = 4'b1000;
    step(1);
    clear = '0;
    chk("ch3_clear_vs_set", 32'({pending[3], missed[3]}), 32'b10);

    // Async reset mid-filter, then release with all inputs high
    mode      = 8'b01_01_01_01;
    signal_in = '1;
    step(SS + 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_level", 32'(level_out), 32'd0);
    chk("async_rst_flags", 32'({pending, missed, edge_dir, irq}), 32'd0);
    step(3);
    rst = 1'b0;
    push('1, '1);
    step(LAT + 2);
    chk("release_level", 32'(level_out), 32'hF);
    chk("release_pending", 32'(pending), 32'hF);
    do_clear('1);

    // Random multi-channel toggles, held long enough to always be accepted
    mode = '1;
    step(2);
    for (int k = 0; k < 16; k++) begin
      m = N'($urandom_range(1, 15));
      signal_in = signal_in ^ m;
      push(m, signal_in);
      step($urandom_range(LAT + 1, LAT + 7));
    end
    step(LAT + 4);

    chk("queue_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pulse_count_ch%0d", i), 32'(got_cnt[i]), 32'(exp_cnt[i]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
